// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet-locking arbiter sharing one FIFO write port among NUM_REQ streams.
// Ports: clk_i/rstn_i (sync active-low), req_valid_i/req_data_i/req_last_i/req_ready_o
// per requester, fifo_wr_valid_o/fifo_wr_data_o/fifo_wr_ready_i to the FIFO,
// grant_id_o (current or most recent grant), busy_o (grant locked).

package arithm_pkg;

  function automatic int log2ceil(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

module fifo_wr_arbiter
  import arithm_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  localparam int ID_WIDTH  = log2ceil(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          fifo_wr_valid_o,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
  input  logic                          fifo_wr_ready_i,
  output logic [ID_WIDTH-1:0]           grant_id_o,
  output logic                          busy_o
);

  localparam int CNT_WIDTH = log2ceil(MAX_BURST);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [ID_WIDTH-1:0]  rr_ptr;
  logic [ID_WIDTH-1:0]  rr_nx;
  logic [ID_WIDTH-1:0]  grant_nx;
  logic [CNT_WIDTH-1:0] beat_cnt;
  logic [CNT_WIDTH-1:0] cnt_nx;

  logic [ID_WIDTH:0]    sum;
  logic [ID_WIDTH-1:0]  cand;
  logic [ID_WIDTH-1:0]  win;
  logic                 win_found;
  logic                 xfer;
  logic                 release_now;

  // Round-robin search: first valid requester at or above rr_ptr,
  // wrapping past NUM_REQ-1 back to 0.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr} + (ID_WIDTH+1)'(i);
      if (sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
        sum = sum - (ID_WIDTH+1)'(NUM_REQ);
      end
      cand = sum[ID_WIDTH-1:0];
      if (!win_found && req_valid_i[cand]) begin
        win_found = 1'b1;
        win       = cand;
      end
    end
  end

  always_comb begin
    state_nx        = state;
    grant_nx        = grant_id_o;
    rr_nx           = rr_ptr;
    cnt_nx          = beat_cnt;
    req_ready_o     = '0;
    fifo_wr_valid_o = 1'b0;
    fifo_wr_data_o  = '0;
    xfer            = 1'b0;
    release_now     = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_found) begin
          state_nx = LOCKED;
          grant_nx = win;
          cnt_nx   = '0;
        end
      end
      LOCKED: begin
        fifo_wr_valid_o = req_valid_i[grant_id_o];
        fifo_wr_data_o  =
          req_data_i[int'(grant_id_o)*DATA_WIDTH +: DATA_WIDTH];
        req_ready_o[grant_id_o] = fifo_wr_ready_i;
        xfer = req_valid_i[grant_id_o] && fifo_wr_ready_i;
        if (xfer) begin
          release_now = req_last_i[grant_id_o] ||
            (beat_cnt == CNT_WIDTH'(MAX_BURST-1));
          cnt_nx = beat_cnt + CNT_WIDTH'(1);
          if (release_now) begin
            // Counter restarts so it never holds MAX_BURST.
            state_nx = IDLE;
            cnt_nx   = '0;
            if (grant_id_o == ID_WIDTH'(NUM_REQ-1)) begin
              rr_nx = '0;
            end else begin
              rr_nx = grant_id_o + ID_WIDTH'(1);
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      beat_cnt   <= '0;
      grant_id_o <= '0;
    end else begin
      state      <= state_nx;
      rr_ptr     <= rr_nx;
      beat_cnt   <= cnt_nx;
      grant_id_o <= grant_nx;
    end
  end

  assign busy_o = (state == LOCKED);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level arbitration model.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    req_last = '0;
  logic [NR-1:0]    req_ready;
  logic             fifo_wr_valid;
  logic [DW-1:0]    fifo_wr_data;
  logic             fifo_rdy_in = 1'b0;
  logic [1:0]       grant_id;
  logic             busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ(NR),
    .DATA_WIDTH(DW),
    .MAX_BURST(MB)
  ) dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .req_valid_i(req_valid),
    .req_data_i(req_data),
    .req_last_i(req_last),
    .req_ready_o(req_ready),
    .fifo_wr_valid_o(fifo_wr_valid),
    .fifo_wr_data_o(fifo_wr_data),
    .fifo_wr_ready_i(fifo_rdy_in),
    .grant_id_o(grant_id),
    .busy_o(busy)
  );

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] qd [NR][$];
  bit            ql [NR][$];
  logic [DW-1:0] log_d [$];
  int            log_id [$];
  logic [DW-1:0] exp_d [$];
  int            exp_id [$];
  logic          rdy = 1'b1;

  // Model: owner = locked requester (-1 when none), gid = last grant,
  // ptr = where the next search starts, beats = beats in this grant.
  int m_owner = -1;
  int m_gid = 0;
  int m_ptr = 0;
  int m_beats = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [DW-1:0] dat, input bit last);
    qd[k].push_back(dat);
    ql[k].push_back(last);
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < NR; k++) begin
      if (qd[k].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic step();
    logic [NR-1:0]    v;
    logic [NR-1:0]    l;
    logic [NR*DW-1:0] d;
    logic [NR-1:0]    e_rdy;
    logic             e_val;
    logic [DW-1:0]    e_dat;
    v = '0;
    l = '0;
    d = '0;
    for (int k = 0; k < NR; k++) begin
      if (qd[k].size() > 0) begin
        v[k] = 1'b1;
        d[k*DW +: DW] = qd[k][0];
        l[k] = ql[k][0];
      end else begin
        d[k*DW +: DW] = $urandom;
        l[k] = 1'($urandom_range(0, 1));
      end
    end
    req_valid   = v;
    req_data    = d;
    req_last    = l;
    fifo_rdy_in = rdy;
    @(negedge clk);
    e_rdy = '0;
    e_val = 1'b0;
    e_dat = '0;
    if (m_owner >= 0) begin
      e_val = v[m_owner];
      e_dat = d[m_owner*DW +: DW];
      if (rdy) e_rdy[m_owner] = 1'b1;
    end
    chk("req_ready", 64'(req_ready), 64'(e_rdy));
    chk("wr_valid", 64'(fifo_wr_valid), 64'(e_val));
    chk("wr_data", 64'(fifo_wr_data), 64'(e_dat));
    chk("grant_id", 64'(grant_id), 64'(m_gid));
    chk("busy", 64'(busy), 64'(m_owner >= 0));
    if (fifo_wr_valid && rdy) begin
      log_d.push_back(fifo_wr_data);
      log_id.push_back(int'(grant_id));
    end
    for (int k = 0; k < NR; k++) begin
      if (req_ready[k] && v[k] && qd[k].size() > 0) begin
        void'(qd[k].pop_front());
        void'(ql[k].pop_front());
      end
    end
    if (!rstn) begin
      m_owner = -1;
      m_ptr   = 0;
      m_gid   = 0;
      m_beats = 0;
    end else if (m_owner < 0) begin
      for (int i = 0; i < NR; i++) begin
        int c;
        c = (m_ptr + i) % NR;
        if (v[c]) begin
          m_owner = c;
          m_gid   = c;
          m_beats = 0;
          break;
        end
      end
    end else if (v[m_owner] && rdy) begin
      m_beats++;
      if (l[m_owner] || m_beats == MB) begin
        m_ptr   = (m_owner + 1) % NR;
        m_owner = -1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int maxc, output int n);
    n = 0;
    while (!all_empty() && n < maxc) begin
      step();
      n++;
    end
    chk("drain_done", 64'(all_empty()), 64'(1));
  endtask

  task automatic wait_log(input int target, input int maxc);
    int n;
    n = 0;
    while (log_d.size() < target && n < maxc) begin
      step();
      n++;
    end
    chk("wait_log", 64'(log_d.size() >= target), 64'(1));
  endtask

  task automatic cmp_log(input string tag);
    int n;
    chk({tag, "_len"}, 64'(log_d.size()), 64'(exp_d.size()));
    n = (log_d.size() < exp_d.size()) ? log_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_id"}, 64'(log_id[i]), 64'(exp_id[i]));
      chk({tag, "_dat"}, 64'(log_d[i]), 64'(exp_d[i]));
    end
    log_d.delete();
    log_id.delete();
    exp_d.delete();
    exp_id.delete();
  endtask

  initial begin
    int n;
    int pushed;
    rstn = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with every requester valid; first grant goes to 0.
    for (int k = 0; k < NR; k++) push(k, 32'h10 + k, 1'b1);
    step();
    step();
    rstn = 1'b1;
    drain(40, n);
    exp_id = {0, 1, 2, 3};
    exp_d  = {32'h10, 32'h11, 32'h12, 32'h13};
    cmp_log("reset_order");

    // Round-robin over 0,1,3 with single-beat packets.
    for (int r = 0; r < 2; r++) begin
      push(0, 32'h000 + r, 1'b1);
      push(1, 32'h100 + r, 1'b1);
      push(3, 32'h300 + r, 1'b1);
    end
    drain(40, n);
    chk("rr_cycles", 64'(n), 64'(12));
    exp_id = {0, 1, 3, 0, 1, 3};
    exp_d  = {32'h000, 32'h100, 32'h300, 32'h001, 32'h101, 32'h301};
    cmp_log("rr");

    // Packet lock: req1 3-beat packet while req2 waits.
    push(1, 32'hA1, 1'b0);
    push(1, 32'hA2, 1'b0);
    push(1, 32'hA3, 1'b1);
    push(2, 32'hB1, 1'b1);
    drain(40, n);
    chk("lock_cycles", 64'(n), 64'(6));
    exp_id = {1, 1, 1, 2};
    exp_d  = {32'hA1, 32'hA2, 32'hA3, 32'hB1};
    cmp_log("lock");

    // Burst cap: 7-beat packet splits into 4 + 3.
    for (int i = 0; i < 7; i++) push(2, 32'hD0 + i, i == 6);
    drain(40, n);
    chk("burst_cycles", 64'(n), 64'(9));
    for (int i = 0; i < 7; i++) begin
      exp_id.push_back(2);
      exp_d.push_back(32'hD0 + i);
    end
    cmp_log("burst");

    // Backpressure mid-packet.
    push(0, 32'hE0, 1'b0);
    push(0, 32'hE1, 1'b0);
    push(0, 32'hE2, 1'b1);
    rdy = 1'b1;
    wait_log(1, 10);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_busy", 64'(busy), 64'(1));
      chk("bp_gid", 64'(grant_id), 64'(0));
    end
    rdy = 1'b1;
    drain(40, n);
    exp_id = {0, 0, 0};
    exp_d  = {32'hE0, 32'hE1, 32'hE2};
    cmp_log("bp");

    // Reset during beat 2 of a req3 packet.
    for (int i = 0; i < 4; i++) push(3, 32'hC0 + i, i == 3);
    wait_log(1, 10);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_gid", 64'(grant_id), 64'(0));
    for (int k = 0; k < NR; k++) begin
      qd[k].delete();
      ql[k].delete();
    end
    log_d.delete();
    log_id.delete();
    push(1, 32'hF0, 1'b1);
    push(3, 32'hF1, 1'b1);
    drain(40, n);
    exp_id = {1, 3};
    exp_d  = {32'hF0, 32'hF1};
    cmp_log("post_rst");

    // Random traffic with random FIFO backpressure.
    pushed = 0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NR; k++) begin
        if (qd[k].size() == 0 && $urandom_range(0, 3) == 0) begin
          int len;
          len = int'($urandom_range(1, 6));
          for (int b = 0; b < len; b++) push(k, $urandom, b == len - 1);
          pushed += len;
        end
      end
      rdy = ($urandom_range(0, 3) != 0);
      step();
    end
    rdy = 1'b1;
    drain(300, n);
    chk("rand_beats", 64'(log_d.size()), 64'(pushed));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
